// File: rtl/iob_fifo_asym_drain_ctrl_if.sv
// Handshake bundle between the asymmetric-FIFO drain controller, the FIFO read
// port and the downstream valid/ready sink.
interface iob_fifo_asym_drain_ctrl_if #(
    parameter int R_DATA_W = 32,
    parameter int RATIO    = 4
);
    logic [31:0]                fifo_ocupancy;
    logic                       fifo_read_en;
    logic [R_DATA_W-1:0]        fifo_data_out;
    logic [R_DATA_W-1:0]        m_data;
    logic                       m_valid;
    logic                       m_ready;
    logic                       m_last;
    logic                       flush;
    logic                       flush_done;
    logic [$clog2(RATIO)-1:0]   leftover;
    logic                       busy;

    // Controller side
    modport master (
        input  fifo_ocupancy, fifo_data_out, m_ready, flush,
        output fifo_read_en, m_data, m_valid, m_last, flush_done, leftover, busy
    );

    // FIFO / sink / environment side
    modport slave (
        output fifo_ocupancy, fifo_data_out, m_ready, flush,
        input  fifo_read_en, m_data, m_valid, m_last, flush_done, leftover, busy
    );
endinterface

// File: rtl/iob_fifo_asym_drain_ctrl.sv
// Read-side burst controller for a narrow-write/wide-read FIFO: reads only
// complete wide words and drains them as valid/ready bursts.
module iob_fifo_asym_drain_ctrl #(
    parameter int R_DATA_W  = 32,
    parameter int RATIO     = 4,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    iob_fifo_asym_drain_ctrl_if.master  bus
);
    localparam int          LOG2R = $clog2(RATIO);
    localparam int          LW    = $clog2(BURST_LEN + 1);
    localparam int          TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TEXP = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [31:0] BL32  = 32'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

    state_t                 r_state;
    logic [LW-1:0]          r_len;
    logic [LW-1:0]          r_beat;
    logic [TW-1:0]          r_tcnt;
    logic                   r_flush_pending;
    logic                   r_read_en;
    logic                   r_flush_done;
    logic [R_DATA_W-1:0]    r_m_data;
    logic                   r_m_valid;
    logic                   r_m_last;

    logic [31:0]            w_avail;
    logic                   w_has;
    logic                   w_full;
    logic                   w_expired;
    logic                   w_start;
    logic                   w_flush_clr;
    logic [LW-1:0]          w_len_start;

    // Occupancy counts narrow words; only whole wide words are eligible.
    assign w_avail     = bus.fifo_ocupancy >> LOG2R;
    assign w_has       = (w_avail != 32'd0);
    assign w_full      = (w_avail >= BL32);
    assign w_expired   = (TIMEOUT != 0) && (r_tcnt == TEXP);
    assign w_start     = w_full || (w_has && (w_expired || r_flush_pending));
    assign w_flush_clr = (r_state == IDLE) && !w_has && r_flush_pending;
    assign w_len_start = w_full ? LW'(BURST_LEN) : LW'(w_avail);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_len           <= '0;
            r_beat          <= '0;
            r_tcnt          <= '0;
            r_flush_pending <= 1'b0;
            r_read_en       <= 1'b0;
            r_flush_done    <= 1'b0;
            r_m_data        <= '0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
        end else begin
            r_read_en    <= 1'b0;
            r_flush_done <= 1'b0;

            // A flush landing on the same cycle the pending one retires is absorbed.
            if (w_flush_clr) begin
                r_flush_pending <= 1'b0;
                r_flush_done    <= 1'b1;
            end else if (bus.flush) begin
                r_flush_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_len     <= w_len_start;
                        r_beat    <= '0;
                        r_tcnt    <= '0;
                        r_read_en <= 1'b1;
                        r_state   <= READ;
                    end else if (!w_has) begin
                        r_tcnt <= '0;
                    end else if ((TIMEOUT != 0) && !w_expired) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                READ: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_m_data  <= bus.fifo_data_out;
                    r_m_valid <= 1'b1;
                    r_m_last  <= (r_beat == r_len - LW'(1));
                    r_state   <= SEND;
                end
                SEND: begin
                    if (r_m_valid && bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_beat    <= r_beat + LW'(1);
                        if (r_m_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_read_en <= 1'b1;
                            r_state   <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_read_en = r_read_en;
    assign bus.m_data       = r_m_data;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_last       = r_m_last;
    assign bus.flush_done   = r_flush_done;
    assign bus.leftover     = bus.fifo_ocupancy[LOG2R-1:0];
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_iob_fifo_asym_drain_ctrl.sv
// Bench for iob_fifo_asym_drain_ctrl: behavioural asymmetric FIFO plus a
// scoreboard of expected wide words, one task per scenario.
module tb_iob_fifo_asym_drain_ctrl;
    localparam int RDW   = 32;
    localparam int RATIO = 4;
    localparam int BL    = 8;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iob_fifo_asym_drain_ctrl_if #(.R_DATA_W(RDW), .RATIO(RATIO)) bus ();

    iob_fifo_asym_drain_ctrl #(
        .R_DATA_W(RDW), .RATIO(RATIO), .BURST_LEN(BL), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  wr_q[$];
    logic [7:0]  fq[$];
    logic [7:0]  stash[$];
    logic [31:0] exp_q[$];
    logic [7:0]  next_byte = 8'h00;
    logic        fifo_clr = 1'b0;

    int          rd_cnt = 0, beats = 0, last_cnt = 0, last_idx = 0, done_cnt = 0;
    logic        done_busy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] m_exp;

    // FIFO model: read data and occupancy update one cycle after the strobe.
    int          md_n;
    logic        md_rd, md_clr;
    logic [31:0] md_w;
    always @(posedge clk) begin
        md_rd  = bus.fifo_read_en;
        md_clr = fifo_clr;
        md_n   = wr_q.size();
        #1;
        if (md_clr) fq.delete();
        else if (md_rd && fq.size() >= RATIO) begin
            for (int k = 0; k < RATIO; k++) md_w[k*8 +: 8] = fq.pop_front();
            bus.fifo_data_out = md_w;
        end
        for (int k = 0; k < md_n; k++) fq.push_back(wr_q.pop_front());
        bus.fifo_ocupancy = 32'(fq.size());
    end

    // Monitor: scoreboard compare, stall stability, no read without a whole word.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_read_en) begin
                rd_cnt++;
                checks++;
                if (bus.fifo_ocupancy < 32'(RATIO)) begin
                    errors++;
                    $display("FAIL read_on_partial: occupancy=%0d required>=%0d", bus.fifo_ocupancy, RATIO);
                end
            end
            if (bus.flush_done) begin
                done_cnt++;
                done_busy = bus.busy;
            end
            if (prev_stall) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                beats++;
                if (bus.m_last) begin
                    last_cnt++;
                    last_idx = beats;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_data: got %h with no expected word queued", bus.m_data);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (bus.m_data !== m_exp) begin
                        errors++;
                        $display("FAIL sb_data: got %h required %h", bus.m_data, m_exp);
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_words(input int n);
        logic [31:0] w;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            wr_q.push_back(next_byte);
            stash.push_back(next_byte);
            next_byte = next_byte + 8'd1;
            if (stash.size() == RATIO) begin
                for (int j = 0; j < RATIO; j++) w[j*8 +: 8] = stash[j];
                exp_q.push_back(w);
                stash.delete();
            end
        end
    endtask

    task automatic clear_fifo();
        @(posedge clk); #1 fifo_clr = 1'b1;
        @(posedge clk); #1 fifo_clr = 1'b0;
        stash.delete();
        exp_q.delete();
    endtask

    task automatic clr_stats();
        rd_cnt = 0; beats = 0; last_cnt = 0; last_idx = 0; done_cnt = 0; done_busy = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (beats >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
        checks++; if (bus.fifo_read_en !== 1'b0) begin errors++; $display("FAIL rst_read_en: got %b required 0", bus.fifo_read_en); end
        checks++; if (bus.busy !== 1'b0 || bus.flush_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b required 00", bus.busy, bus.flush_done); end
        checks++; if (bus.m_data !== '0 || bus.m_last !== 1'b0) begin errors++; $display("FAIL rst_data_last: got %h/%b required 0/0", bus.m_data, bus.m_last); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_threshold();
        bit ok;
        clr_stats();
        bus.m_ready = 1'b1;
        write_words(32);
        wait_beats(8, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL thr_timeout: beats=%0d required 8", beats); end
        repeat (20) @(negedge clk);
        checks++; if (beats != 8 || rd_cnt != 8) begin errors++; $display("FAIL thr_counts: beats=%0d reads=%0d required 8/8", beats, rd_cnt); end
        checks++; if (last_cnt != 1 || last_idx != 8) begin errors++; $display("FAIL thr_last: count=%0d at=%0d required 1 at 8", last_cnt, last_idx); end
        checks++; if (bus.fifo_ocupancy !== 32'd0) begin errors++; $display("FAIL thr_occ: got %0d required 0", bus.fifo_ocupancy); end
    endtask

    task automatic test_stall();
        clr_stats();
        bus.m_ready = 1'b0;
        write_words(32);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 bus.m_ready = (i % 4 == 0);
            if (beats >= 8) break;
        end
        bus.m_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (beats != 8 || last_cnt != 1 || last_idx != 8) begin errors++; $display("FAIL stall_beats: beats=%0d last=%0d at %0d required 8,1,8", beats, last_cnt, last_idx); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_sb_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int first;
        clear_fifo();
        clr_stats();
        bus.m_ready = 1'b1;
        write_words(10);
        first = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.fifo_read_en && first == 0) first = i;
        end
        // 2 negedges before the DUT sees occupancy, then TIMEOUT idle cycles
        checks++; if (first != 2 + TO) begin errors++; $display("FAIL to_latency: first read at %0d required %0d", first, 2 + TO); end
        repeat (40) @(negedge clk);
        checks++; if (beats != 2 || rd_cnt != 2) begin errors++; $display("FAIL to_counts: beats=%0d reads=%0d required 2/2", beats, rd_cnt); end
        checks++; if (last_cnt != 1 || last_idx != 2) begin errors++; $display("FAIL to_last: count=%0d at=%0d required 1 at 2", last_cnt, last_idx); end
        checks++; if (bus.leftover !== 2'd2 || bus.fifo_ocupancy !== 32'd2) begin errors++; $display("FAIL to_leftover: leftover=%0d occ=%0d required 2/2", bus.leftover, bus.fifo_ocupancy); end
    endtask

    task automatic test_flush();
        clear_fifo();
        clr_stats();
        bus.m_ready = 1'b1;
        write_words(6);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL fl_done_cnt: got %0d required 1", done_cnt); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL fl_done_busy: got %b required 0", done_busy); end
        checks++; if (beats != 1 || rd_cnt != 1 || last_idx != 1) begin errors++; $display("FAIL fl_counts: beats=%0d reads=%0d last_at=%0d required 1/1/1", beats, rd_cnt, last_idx); end
        checks++; if (bus.leftover !== 2'd2 || bus.fifo_ocupancy !== 32'd2) begin errors++; $display("FAIL fl_leftover: leftover=%0d occ=%0d required 2/2", bus.leftover, bus.fifo_ocupancy); end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        clear_fifo();
        clr_stats();
        bus.m_ready = 1'b1;
        write_words(32);
        wait_beats(2, 100, ok);
        bus.m_ready = 1'b0;
        bus.flush = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL rb_reach: beats=%0d required 2", beats); end
        @(posedge clk); #1 bus.flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.m_valid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rb_beat3: m_valid=%b required 1", bus.m_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rb_outputs: valid=%b busy=%b required 0/0", bus.m_valid, bus.busy); end
        checks++; if (bus.fifo_read_en !== 1'b0 || bus.flush_done !== 1'b0) begin errors++; $display("FAIL rb_strobes: read_en=%b flush_done=%b required 0/0", bus.fifo_read_en, bus.flush_done); end
        clear_fifo();
        @(posedge clk); #1 rst = 1'b0;
        clr_stats();
        bus.m_ready = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != 0 || rd_cnt != 0) begin errors++; $display("FAIL rb_pending: done=%0d reads=%0d required 0/0", done_cnt, rd_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_fifo();
        clr_stats();
        bus.m_ready = 1'b1;
        write_words(32);
        for (int i = 0; i < 8; i++) write_words(4);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (last_cnt >= 1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || last_idx != 8) begin errors++; $display("FAIL b2b_first: last at %0d required 8", last_idx); end
        @(negedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", bus.busy); end
        @(negedge clk); #1;
        checks++; if (bus.fifo_read_en !== 1'b1) begin errors++; $display("FAIL b2b_restart: read_en=%b required 1", bus.fifo_read_en); end
        wait_beats(16, 100, ok);
        repeat (20) @(negedge clk);
        checks++; if (beats != 16 || rd_cnt != 16 || last_cnt != 2) begin errors++; $display("FAIL b2b_counts: beats=%0d reads=%0d lasts=%0d required 16/16/2", beats, rd_cnt, last_cnt); end
        checks++; if (bus.fifo_ocupancy !== 32'd0 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: occ=%0d sb=%0d required 0/0", bus.fifo_ocupancy, exp_q.size()); end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        bus.flush   = 1'b0;
        test_reset();
        test_threshold();
        test_stall();
        test_timeout();
        test_flush();
        test_reset_midburst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
